// File: rtl/dmem_pkg.sv
// Shared widths and response payload type for the data-memory responder.
// The response stamp width depends on LATENCY, so it is added by the top module.
package dmem_pkg;

  localparam int TAG_W  = 11;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              error;
  } resp_payload_t;

  // The stamp needs enough headroom that (now - stamp) stays unambiguous
  // across the counter wrap while responses wait in the queue.
  function automatic int stamp_width(input int latency);
    return $clog2(latency) + 2;
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// Synchronous FIFO for in-order responses with registered count and sync reset.
// A push while full and a pop while empty are ignored.
module dmem_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately left unreset; the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: byte-strobed word array, fixed-latency in-order acks.
// Optional build macro DMEM_FUZZ_STALL_EN lets stall_i gate both accept and ack.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2,
  parameter int          OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] mem_d_addr_i,
  input  logic [DATA_W-1:0] mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [STRB_W-1:0] mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  input  logic              stall_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,
  output logic [DATA_W-1:0] mem_d_data_rd_o
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int STAMP_W = stamp_width(LATENCY);
  localparam int CNT_W   = $clog2(OUTSTANDING) + 1;

  typedef struct packed {
    resp_payload_t      payload;
    logic [STAMP_W-1:0] stamp;
  } resp_entry_t;

  localparam int ENTRY_W = $bits(resp_entry_t);

  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];
  logic [STAMP_W-1:0] stamp_q;
  resp_payload_t      hold_q;
  resp_entry_t        push_entry;
  resp_entry_t        head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               stall_gate;
  logic               wr_any;
  logic               is_access;
  logic               req;
  logic               handshake;
  logic               pop;
  logic [ADDR_W-1:0]  offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  old_word;
  logic [STAMP_W-1:0] age;

`ifdef DMEM_FUZZ_STALL_EN
  assign stall_gate = stall_i;
`else
  assign stall_gate = 1'b0;
  logic unused_stall;
  assign unused_stall = stall_i;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{mem_d_cacheable_i, offset[1:0], fifo_full};

  // Request decode
  assign wr_any    = |mem_d_wr_i;
  assign is_access = mem_d_rd_i | wr_any;
  assign req       = is_access | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;

  assign offset    = mem_d_addr_i - BASE_ADDR;
  assign in_range  = (mem_d_addr_i >= BASE_ADDR) &&
                     ({2'b00, offset[ADDR_W-1:2]} < ADDR_W'(DEPTH_WORDS));
  assign idx       = offset[IDX_W+1:2];
  assign old_word  = mem_q[idx];

  // Accept looks at the registered count, so a same-cycle pop frees no slot yet.
  assign mem_d_accept_o = ~rst_i & (fifo_count < CNT_W'(OUTSTANDING)) & ~stall_gate;
  assign handshake      = req & mem_d_accept_o;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_entry             = '0;
    push_entry.payload.tag = mem_d_req_tag_i;
    push_entry.stamp       = stamp_q;
    if (is_access && !in_range) begin
      push_entry.payload.error = 1'b1;
    end else if (mem_d_rd_i) begin
      push_entry.payload.data = old_word;
    end
  end

  // Writes land at the edge, so a combined read/write returns the old word.
  always_ff @(posedge clk_i) begin
    if (handshake && in_range) begin
      for (int n = 0; n < STRB_W; n++) begin
        if (mem_d_wr_i[n]) mem_q[idx][8*n +: 8] <= mem_d_data_wr_i[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stamp_q <= '0;
    else       stamp_q <= stamp_q + 1'b1;
  end

  dmem_resp_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Modular age keeps working across the stamp wrap for bounded waits.
  assign age = stamp_q - head.stamp;
  assign pop = ~rst_i & ~fifo_empty & (age >= STAMP_W'(LATENCY)) & ~stall_gate;

  always_ff @(posedge clk_i) begin
    if (rst_i)    hold_q <= '0;
    else if (pop) hold_q <= head.payload;
  end

  assign mem_d_ack_o      = pop;
  assign mem_d_resp_tag_o = pop ? head.payload.tag   : hold_q.tag;
  assign mem_d_data_rd_o  = pop ? head.payload.data  : hold_q.data;
  assign mem_d_error_o    = pop ? head.payload.error : hold_q.error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a default instance plus a long-latency
// instance used to exercise the full-queue and mid-flight reset cases.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT    = 2;
  localparam int LAT_BP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i     = 1'b1;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic        rd        = 1'b0;
  logic [3:0]  wr        = '0;
  logic        cacheable = 1'b0;
  logic [10:0] tag       = '0;
  logic        inv       = 1'b0;
  logic        wb        = 1'b0;
  logic        flush     = 1'b0;
  logic        stall     = 1'b0;
  logic        accept, ack, err;
  logic [10:0] rtag;
  logic [31:0] rdata;

  logic [31:0] bp_addr = 32'h8000_0040;
  logic        bp_rd   = 1'b0;
  logic [10:0] bp_tag  = '0;
  logic        bp_accept, bp_ack, bp_err;
  logic [10:0] bp_rtag;
  logic [31:0] bp_rdata;

  dmem_responder dut (
    .clk_i(clk), .rst_i(rst_i), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata),
    .mem_d_rd_i(rd), .mem_d_wr_i(wr), .mem_d_cacheable_i(cacheable),
    .mem_d_req_tag_i(tag), .mem_d_invalidate_i(inv), .mem_d_writeback_i(wb),
    .mem_d_flush_i(flush), .stall_i(stall), .mem_d_accept_o(accept),
    .mem_d_ack_o(ack), .mem_d_error_o(err), .mem_d_resp_tag_o(rtag),
    .mem_d_data_rd_o(rdata)
  );

  dmem_responder #(.LATENCY(LAT_BP)) dut_bp (
    .clk_i(clk), .rst_i(rst_i), .mem_d_addr_i(bp_addr), .mem_d_data_wr_i(32'h0),
    .mem_d_rd_i(bp_rd), .mem_d_wr_i(4'h0), .mem_d_cacheable_i(1'b0),
    .mem_d_req_tag_i(bp_tag), .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0),
    .mem_d_flush_i(1'b0), .stall_i(1'b0), .mem_d_accept_o(bp_accept),
    .mem_d_ack_o(bp_ack), .mem_d_error_o(bp_err), .mem_d_resp_tag_o(bp_rtag),
    .mem_d_data_rd_o(bp_rdata)
  );

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
    bit          exact;
  } exp_t;

  exp_t sb_q[$];
  exp_t bp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor for the default instance.
  always @(negedge clk) begin : mon_main
    exp_t e;
    #2;
    if (ack === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_ack: cyc=%0d tag=%h data=%h err=%b, nothing outstanding",
                 cyc, rtag, rdata, err);
      end else begin
        e = sb_q.pop_front();
        if (rtag !== e.tag || rdata !== e.data || err !== e.err ||
            (cyc - e.acc_cyc) < LAT || (e.exact && (cyc - e.acc_cyc) != LAT)) begin
          tests_failed++;
          $display("FAIL resp: got tag=%h data=%h err=%b lat=%0d, want tag=%h data=%h err=%b lat%s%0d",
                   rtag, rdata, err, cyc - e.acc_cyc, e.tag, e.data, e.err,
                   e.exact ? "=" : ">=", LAT);
        end
      end
    end
  end

  // Response monitor for the long-latency instance (its array is never written).
  always @(negedge clk) begin : mon_bp
    exp_t e;
    #2;
    if (bp_ack === 1'b1) begin
      tests_run++;
      if (bp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL bp_unexpected_ack: cyc=%0d tag=%h, nothing outstanding", cyc, bp_rtag);
      end else begin
        e = bp_q.pop_front();
        if (bp_rtag !== e.tag || bp_err !== e.err ||
            (cyc - e.acc_cyc) < LAT_BP || (e.exact && (cyc - e.acc_cyc) != LAT_BP)) begin
          tests_failed++;
          $display("FAIL bp_resp: got tag=%h err=%b lat=%0d, want tag=%h err=%b lat%s%0d",
                   bp_rtag, bp_err, cyc - e.acc_cyc, e.tag, e.err, e.exact ? "=" : ">=", LAT_BP);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_bus();
    rd = 1'b0; wr = '0; inv = 1'b0; wb = 1'b0; flush = 1'b0;
  endtask

  // m = {invalidate, writeback, flush}
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic [3:0] w, input logic [10:0] t, input logic [2:0] m,
                       input logic [31:0] ed, input logic ee, input bit exact);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(negedge clk);
    addr = a; wdata = d; rd = r; wr = w; tag = t;
    {inv, wb, flush} = m;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (accept === 1'b1) begin
        e = '{t, ed, ee, cyc, exact};
        sb_q.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: tag=%h never accepted", t);
    end
    @(posedge clk);
    #1 clear_bus();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && (sb_q.size() != 0 || bp_q.size() != 0); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0 || bp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d main and %0d bp responses never acked, want 0",
               sb_q.size(), bp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({accept, ack, err, rtag, rdata, bp_accept} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: accept=%b ack=%b err=%b tag=%h data=%h bp_accept=%b, want all 0",
               accept, ack, err, rtag, rdata, bp_accept);
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (accept !== 1'b1 || ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_accept: accept=%b ack=%b, want accept=1 ack=0", accept, ack);
    end
  endtask

  task automatic test_write_read();
    issue(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 4'hF, 11'd5, 3'b000, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'd6, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_byte_strobes();
    issue(32'h8000_0020, 32'h1122_3344, 1'b0, 4'hF,    11'd7,  3'b000, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0020, 32'hAABB_CCDD, 1'b0, 4'b0101, 11'd8,  3'b000, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0020, 32'h0,         1'b1, 4'h0,    11'd9,  3'b000, 32'h11BB_33DD, 1'b0, 1'b1);
    issue(32'h8000_0020, 32'h0000_0055, 1'b1, 4'hF,    11'd10, 3'b000, 32'h11BB_33DD, 1'b0, 1'b1);
    issue(32'h8000_0020, 32'h0,         1'b1, 4'h0,    11'd11, 3'b000, 32'h0000_0055, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_out_of_range();
    issue(32'h8000_0000, 32'hCAFE_F00D, 1'b0, 4'hF, 11'd1,   3'b000, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0FFC, 32'h0BAD_C0DE, 1'b0, 4'hF, 11'd2,   3'b000, 32'h0, 1'b0, 1'b1);
    issue(32'h7FFF_FFFC, 32'h0,         1'b1, 4'h0, 11'h7FF, 3'b000, 32'h0, 1'b1, 1'b1);
    issue(32'h8000_1000, 32'h1234_5678, 1'b0, 4'hF, 11'd3,   3'b000, 32'h0, 1'b1, 1'b1);
    issue(32'h7FFF_FFFC, 32'h0,         1'b0, 4'h0, 11'd4,   3'b100, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_1000, 32'h0,         1'b0, 4'h0, 11'd12,  3'b001, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0040, 32'h0,         1'b0, 4'h0, 11'd13,  3'b010, 32'h0, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h0,         1'b1, 4'h0, 11'd14,  3'b000, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(32'h8000_0FFC, 32'h0,         1'b1, 4'h0, 11'd15,  3'b000, 32'h0BAD_C0DE, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++)
      issue(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'(16 + k), 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_drain();
  endtask

  // Long-latency instance: the fifth read must wait until the first ack has popped.
  task automatic test_backpressure();
    int   k;
    logic exp_acc;
    exp_t e;
    k = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (k < 5) begin
        bp_rd = 1'b1; bp_tag = 11'(k);
        #1;
        exp_acc = (j < 4) || (j > LAT_BP);
        tests_run++;
        if (bp_accept !== exp_acc) begin
          tests_failed++;
          $display("FAIL bp_accept: step %0d got %b, want %b", j, bp_accept, exp_acc);
        end
        if (bp_accept === 1'b1) begin
          e = '{11'(k), 32'h0, 1'b0, cyc, 1'b1};
          bp_q.push_back(e);
          k++;
        end
      end else begin
        bp_rd = 1'b0;
      end
    end
    bp_rd = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_flight();
    int n_ack;
    issue(32'h8000_0080, 32'h600D_F00D, 1'b0, 4'hF, 11'd30, 3'b000, 32'h0, 1'b0, 1'b1);
    wait_drain();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bp_rd = 1'b1; bp_tag = 11'(40 + j);
      #1;
      tests_run++;
      if (bp_accept !== 1'b1) begin
        tests_failed++;
        $display("FAIL midflight_accept: req %0d got accept=%b, want 1", j, bp_accept);
      end
    end
    @(negedge clk);
    bp_rd = 1'b0;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (accept !== 1'b0 || bp_accept !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_in_reset: accept=%b bp_accept=%b, want 0 0", accept, bp_accept);
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({ack, err, rtag, rdata, bp_ack, bp_err, bp_rtag, bp_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL outputs_after_reset: tag=%h data=%h bp_tag=%h bp_data=%h, want 0",
               rtag, rdata, bp_rtag, bp_rdata);
    end
    n_ack = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      #1;
      if (bp_ack === 1'b1) n_ack++;
    end
    tests_run++;
    if (n_ack != 0) begin
      tests_failed++;
      $display("FAIL acks_after_reset: got %0d, want 0", n_ack);
    end
    issue(32'h8000_0080, 32'h0, 1'b1, 4'h0, 11'd31, 3'b000, 32'h600D_F00D, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_stall();
`ifdef DMEM_FUZZ_STALL_EN
    issue(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'h21, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      tests_run++;
      if (ack !== 1'b0 || accept !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: step %0d ack=%b accept=%b, want 0 0", j, ack, accept);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: ack=%b, want 1", ack);
    end
`else
    stall = 1'b1;
    issue(32'h8000_0010, 32'h0, 1'b1, 4'h0, 11'h22, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(32'h8000_0020, 32'h0, 1'b1, 4'h0, 11'h23, 3'b000, 32'h0000_0055, 1'b0, 1'b1);
    stall = 1'b0;
`endif
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flight();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
